// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch resolve, and an
// iterative shift-add multiplier that stalls the ID/EXE latch.
module exe_stage #(
  parameter int len = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           flush,
  input  logic [len-1:0] pc_in,
  input  logic [3:0]     exe_cmd,
  input  logic [1:0]     branch_type,
  input  logic           wb_en,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [31:0]    alu_inp1,
  input  logic [31:0]    alu_inp2,
  input  logic [31:0]    reg2,
  input  logic [4:0]     dest,
  output logic           stall_out,
  output logic           valid_out,
  output logic           wb_en_out,
  output logic           mem_read_out,
  output logic           mem_write_out,
  output logic [31:0]    alu_result_out,
  output logic [31:0]    reg2_out,
  output logic [4:0]     dest_out,
  output logic           br_taken,
  output logic [len-1:0] br_addr
);

  logic           busy;
  logic [4:0]     cnt;
  logic [31:0]    acc;
  logic [31:0]    mcand;
  logic [31:0]    mplier;
  logic [31:0]    acc_nxt;
  logic [31:0]    alu_res;
  logic           br_res;
  logic [len-1:0] addr_res;
  logic           accept;
  logic           is_mul;

  logic           h_wb;
  logic           h_mr;
  logic           h_mw;
  logic           h_br;
  logic [31:0]    h_reg2;
  logic [4:0]     h_dest;
  logic [len-1:0] h_addr;

  assign stall_out = busy;
  assign accept    = in_valid & ~flush & ~busy;
  assign is_mul    = (exe_cmd == 4'b1100);
  assign acc_nxt   = acc + (mplier[0] ? mcand : 32'd0);
  assign addr_res  = pc_in + (len'(alu_inp2) << 2);

  always_comb begin
    alu_res = alu_inp1 + alu_inp2;
    unique case (exe_cmd)
      4'b0010: alu_res = alu_inp1 - alu_inp2;
      4'b0100: alu_res = alu_inp1 & alu_inp2;
      4'b0101: alu_res = alu_inp1 | alu_inp2;
      4'b0110: alu_res = ~(alu_inp1 | alu_inp2);
      4'b0111: alu_res = alu_inp1 ^ alu_inp2;
      4'b1000: alu_res = alu_inp1 << alu_inp2[4:0];
      4'b1001: alu_res = $signed(alu_inp1) >>> alu_inp2[4:0];
      4'b1010: alu_res = alu_inp1 >> alu_inp2[4:0];
      default: alu_res = alu_inp1 + alu_inp2;
    endcase
  end

  always_comb begin
    br_res = 1'b0;
    unique case (branch_type)
      2'b01:   br_res = (alu_inp1 == 32'd0);
      2'b10:   br_res = (alu_inp1 != reg2);
      2'b11:   br_res = 1'b1;
      default: br_res = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy           <= 1'b0;
      cnt            <= 5'd0;
      acc            <= 32'd0;
      mcand          <= 32'd0;
      mplier         <= 32'd0;
      valid_out      <= 1'b0;
      wb_en_out      <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      br_taken       <= 1'b0;
      alu_result_out <= 32'd0;
      reg2_out       <= 32'd0;
      dest_out       <= 5'd0;
      br_addr        <= '0;
      h_wb           <= 1'b0;
      h_mr           <= 1'b0;
      h_mw           <= 1'b0;
      h_br           <= 1'b0;
      h_reg2         <= 32'd0;
      h_dest         <= 5'd0;
      h_addr         <= '0;
    end else begin
      valid_out     <= 1'b0;
      wb_en_out     <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      br_taken      <= 1'b0;
      if (busy) begin
        if (flush) begin
          busy <= 1'b0;
          cnt  <= 5'd0;
        end else begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          // last partial product folds straight into the result
          if (cnt == 5'd31) begin
            busy           <= 1'b0;
            valid_out      <= 1'b1;
            alu_result_out <= acc_nxt;
            wb_en_out      <= h_wb;
            mem_read_out   <= h_mr;
            mem_write_out  <= h_mw;
            br_taken       <= h_br;
            reg2_out       <= h_reg2;
            dest_out       <= h_dest;
            br_addr        <= h_addr;
          end
        end
      end else if (accept) begin
        if (is_mul) begin
          busy   <= 1'b1;
          cnt    <= 5'd0;
          acc    <= 32'd0;
          mcand  <= alu_inp1;
          mplier <= alu_inp2;
          h_wb   <= wb_en;
          h_mr   <= mem_read;
          h_mw   <= mem_write;
          h_br   <= br_res;
          h_reg2 <= reg2;
          h_dest <= dest;
          h_addr <= addr_res;
        end else begin
          valid_out      <= 1'b1;
          alu_result_out <= alu_res;
          wb_en_out      <= wb_en;
          mem_read_out   <= mem_read;
          mem_write_out  <= mem_write;
          br_taken       <= br_res;
          reg2_out       <= reg2;
          dest_out       <= dest;
          br_addr        <= addr_res;
        end
      end
    end
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter: len, 32, width of pc_in and br_addr.
REQ-002 SHALL have ports: clock  input  1  single rising-edge clock.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: in_valid  input  1  ID/EXE latch holds a live instruction.
REQ-005 SHALL have ports: flush  input  1  squash the instruction entering this cycle, and any multiply in progress.
REQ-006 SHALL have ports: pc_in  input  len  PC of the instruction.
REQ-007 SHALL have ports: exe_cmd  input  4, plus branch_type  input  2, and wb_en, mem_read, mem_write  input  1 each.
REQ-008 SHALL have ports: alu_inp1, alu_inp2, reg2  input  32 each, plus dest  input  5.
REQ-009 SHALL have ports: stall_out  output  1  busy; the upstream ID/EXE latch holds while it is high.
REQ-010 SHALL have ports: valid_out, wb_en_out, mem_read_out, mem_write_out  output  1 each; alu_result_out, reg2_out  output  32 each; dest_out  output  5.
REQ-011 SHALL have ports: br_taken  output  1, plus br_addr  output  len.

Function
REQ-012 SHALL accept an instruction on a rising edge when in_valid=1, flush=0 and stall_out=0.
REQ-013 SHALL encode exe_cmd as: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL, 1100 MUL.
REQ-014 SHALL treat any other exe_cmd value as ADD.
REQ-015 SHALL compute all arithmetic modulo 2^32, ignoring overflow.
REQ-016 SHALL shift alu_inp1 by alu_inp2[4:0].
REQ-017 SHALL register non-MUL results with 1-cycle latency: valid_out and all *_out fields update on the accepting edge.
REQ-018 SHALL produce MUL as the low 32 bits of alu_inp1*alu_inp2 (unsigned), using an iterative shift-add unit with a 5-bit counter, one partial product per cycle.
REQ-019 SHALL set busy on the MUL accepting edge T; stall_out SHALL be high from T to T+32.
REQ-020 SHALL, on edge T+32, clear busy and load the MUL result with valid_out=1.
REQ-021 SHALL hold the captured dest, wb_en, mem_read, mem_write and reg2 internally while busy.
REQ-022 SHALL ignore in_valid while busy.
REQ-023 SHALL decode branch_type as: 00 none, 01 BEZ (taken if alu_inp1==0), 10 BNE (taken if alu_inp1!=reg2), 11 JMP (always taken).
REQ-024 SHALL register br_taken with the result, as a 1-cycle pulse qualified by acceptance.
REQ-025 SHALL set br_addr = pc_in + (alu_inp2<<2), modulo 2^len, registered with the result.
REQ-026 SHALL, on any edge that loads no result, set valid_out, wb_en_out, mem_read_out, mem_write_out and br_taken to 0, and hold the data fields.
REQ-027 SHALL, when flush=1 and in_valid=1 occur together, not accept the instruction and produce no output.
REQ-028 SHALL, when flush=1 while busy, abort the multiply: busy clears on that edge, the counter resets to 0, and no result is emitted.
REQ-029 SHALL accept a new instruction on the edge after MUL completion, since stall_out is already low in that cycle.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear busy, the counter, valid_out, wb_en_out, mem_read_out, mem_write_out and br_taken.
REQ-031 SHALL, while reset=0, asynchronously clear alu_result_out, reg2_out, dest_out and br_addr to 0.
REQ-032 SHALL, on reset assertion during a multiply, discard the multiply, and stall_out SHALL fall immediately.

Verification
REQ-033 SHALL cover ADD/SUB: ADD 5+7 -> alu_result_out=12 next edge; SUB 0-1 -> 0xFFFFFFFF; both with valid_out=1.
REQ-034 SHALL cover MUL: 0x0001_0003 * 0x0000_0010 -> stall_out high for 32 cycles, then alu_result_out=0x0010_0030 and valid_out=1 for one cycle.
REQ-035 SHALL cover a flush mid-MUL at cycle 10 -> stall_out low the next cycle, no valid_out, and the following ADD is accepted normally.
REQ-036 SHALL cover branches: BNE with alu_inp1=3, reg2=3 -> br_taken=0; JMP with pc_in=0x100, alu_inp2=4 -> br_taken=1, br_addr=0x110.
REQ-037 SHALL cover simultaneous flush=1 and in_valid=1 on a MEM store -> mem_write_out stays 0 and valid_out stays 0.
REQ-038 SHALL cover reset=0 asserted asynchronously mid-MUL -> all outputs 0 and stall_out=0 before the next clock edge.
